// File: rtl/tetris_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// tetris_defs
//   Definitions shared by the tetris game controller and board datapath:
//   board geometry, row index width, score increment per cleared row, and
//   the sequencer state encoding.
// ---------------------------------------------------------------------------
package tetris_defs;

  localparam int ROWS           = 20;
  localparam int COLS           = 10;
  localparam int ROW_W          = 5;
  localparam int SCORE_W        = 16;
  localparam int SCORE_PER_LINE = 10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_CLEAR,
    S_SPAWN,
    S_CHKSP,
    S_FALL,
    S_LOCK,
    S_SETTLE,
    S_CHECK,
    S_OVER
  } state_t;

endpackage

// File: rtl/line_index_encoder.sv
// ---------------------------------------------------------------------------
// line_index_encoder
//   Combinational priority encoder for completed rows. It returns the index
//   of the lowest full row and a flag that says whether any row is full.
//   Ports:
//     lines_full  in   ROWS    bit r = row r full
//     lowest_row  out  ROW_W   index of the lowest set bit (0 when none set)
//     any_full    out  1       at least one row is full
// ---------------------------------------------------------------------------
module line_index_encoder #(
  parameter int ROWS  = 20,
  parameter int ROW_W = 5
) (
  input  logic [ROWS-1:0]  lines_full,
  output logic [ROW_W-1:0] lowest_row,
  output logic             any_full
);

  always_comb begin
    lowest_row = '0;
    any_full   = |lines_full;
    // Scanning downward lets the lowest full row make the last assignment.
    for (int r = ROWS - 1; r >= 0; r--) begin
      if (lines_full[r]) lowest_row = ROW_W'(r);
    end
  end

endmodule

// File: rtl/tetris_sequencer.sv
// ---------------------------------------------------------------------------
// tetris_sequencer
//   Game-level controller for the tetris board datapath. It moves each piece
//   through spawn, gravity fall, lock and line clear, gates player left/right
//   moves, detects game over and keeps saturating line and score counters.
//   Every output is registered; command outputs are one-cycle pulses.
//   Ports:
//     clock, resetn          framerate clock, async active-low reset
//     start_game             level start request (honoured in IDLE / OVER)
//     tick_fall              gravity pulse (used in FALL only, never queued)
//     key_left, key_right    player keys; one move per rising edge
//     filled_under/left/right  collision flags from the datapath
//     spawn_blocked          new piece overlaps the stack
//     completed_lines        bit r = row r full
//     clear_board, load_block, drop_block, move_left, move_right,
//     update_board_state, shift_down   one-cycle command pulses
//     shift_row              row to remove, valid with shift_down
//     lines, score           saturating counters
//     game_over              level, held while in S_OVER
// ---------------------------------------------------------------------------
module tetris_sequencer #(
  parameter int ROWS           = tetris_defs::ROWS,
  parameter int ROW_W          = tetris_defs::ROW_W,
  parameter int SCORE_W        = tetris_defs::SCORE_W,
  parameter int SCORE_PER_LINE = tetris_defs::SCORE_PER_LINE
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start_game,
  input  logic               tick_fall,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               filled_under,
  input  logic               filled_left,
  input  logic               filled_right,
  input  logic               spawn_blocked,
  input  logic [ROWS-1:0]    completed_lines,
  output logic               clear_board,
  output logic               load_block,
  output logic               drop_block,
  output logic               move_left,
  output logic               move_right,
  output logic               update_board_state,
  output logic               shift_down,
  output logic [ROW_W-1:0]   shift_row,
  output logic [SCORE_W-1:0] lines,
  output logic [SCORE_W-1:0] score,
  output logic               game_over
);

  import tetris_defs::*;

  state_t state, state_nxt;

  logic key_left_d, key_right_d;
  logic left_edge, right_edge;

  logic               drop_nxt, move_left_nxt, move_right_nxt, shift_down_nxt;
  logic [ROW_W-1:0]   shift_row_nxt;
  logic [SCORE_W-1:0] lines_nxt, score_nxt;
  logic [SCORE_W:0]   lines_sum, score_sum;

  logic [ROW_W-1:0]   lowest_row;
  logic               any_full;

  line_index_encoder #(
    .ROWS  (ROWS),
    .ROW_W (ROW_W)
  ) u_line_index_encoder (
    .lines_full (completed_lines),
    .lowest_row (lowest_row),
    .any_full   (any_full)
  );

  assign left_edge  = key_left  & ~key_left_d;
  assign right_edge = key_right & ~key_right_d;

  // One extra bit catches the carry so the counters clamp instead of wrapping.
  assign lines_sum = {1'b0, lines} + (SCORE_W + 1)'(1);
  assign score_sum = {1'b0, score} + (SCORE_W + 1)'(SCORE_PER_LINE);

  // NOTE: every signal written here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_nxt      = state;
    drop_nxt       = 1'b0;
    move_left_nxt  = 1'b0;
    move_right_nxt = 1'b0;
    shift_down_nxt = 1'b0;
    shift_row_nxt  = '0;
    lines_nxt      = lines;
    score_nxt      = score;

    unique case (state)
      S_IDLE:  if (start_game) state_nxt = S_CLEAR;
      S_CLEAR: begin
        lines_nxt = '0;
        score_nxt = '0;
        state_nxt = S_SPAWN;
      end
      S_SPAWN: state_nxt = S_CHKSP;
      S_CHKSP: state_nxt = spawn_blocked ? S_OVER : S_FALL;
      S_FALL: begin
        // Gravity wins over the keys; a key edge in a tick cycle is lost.
        if (tick_fall) begin
          if (filled_under) state_nxt = S_LOCK;
          else              drop_nxt  = 1'b1;
        end else if (!(left_edge && right_edge)) begin
          move_left_nxt  = left_edge  & ~filled_left;
          move_right_nxt = right_edge & ~filled_right;
        end
      end
      S_LOCK:   state_nxt = S_SETTLE;
      S_SETTLE: state_nxt = S_CHECK;
      S_CHECK: begin
        if (any_full) begin
          shift_down_nxt = 1'b1;
          shift_row_nxt  = lowest_row;
          lines_nxt      = lines_sum[SCORE_W] ? '1 : lines_sum[SCORE_W-1:0];
          score_nxt      = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];
          state_nxt      = S_SETTLE;
        end else begin
          state_nxt = S_SPAWN;
        end
      end
      S_OVER:  if (start_game) state_nxt = S_CLEAR;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state              <= S_IDLE;
      key_left_d         <= 1'b0;
      key_right_d        <= 1'b0;
      clear_board        <= 1'b0;
      load_block         <= 1'b0;
      drop_block         <= 1'b0;
      move_left          <= 1'b0;
      move_right         <= 1'b0;
      update_board_state <= 1'b0;
      shift_down         <= 1'b0;
      shift_row          <= '0;
      lines              <= '0;
      score              <= '0;
      game_over          <= 1'b0;
    end else begin
      state              <= state_nxt;
      key_left_d         <= key_left;
      key_right_d        <= key_right;
      // State-entry commands are decoded from the next state so each pulse
      // lines up with the cycle the sequencer spends in that state.
      clear_board        <= (state_nxt == S_CLEAR);
      load_block         <= (state_nxt == S_SPAWN);
      update_board_state <= (state_nxt == S_LOCK);
      game_over          <= (state_nxt == S_OVER);
      drop_block         <= drop_nxt;
      move_left          <= move_left_nxt;
      move_right         <= move_right_nxt;
      shift_down         <= shift_down_nxt;
      shift_row          <= shift_row_nxt;
      lines              <= lines_nxt;
      score              <= score_nxt;
    end
  end

endmodule
